// File: rtl/repetition_scrubber.sv
// Background scrubber: sweeps a repetition-coded memory, majority-votes each word and
// writes back a re-encoded block on any copy mismatch. Optional macro: REPETITION_SCRUBBER_PERIODIC_EN.
module repetition_scrubber #(
  parameter int DATA_WIDTH     = 8,
  parameter int REPETITION     = 3,
  parameter int DEPTH          = 16,
  parameter int COUNT_WIDTH    = 16,
  parameter int SCRUB_INTERVAL = 1024,
  localparam int BLOCK_WIDTH   = REPETITION * DATA_WIDTH,
  localparam int ADDRESS_WIDTH = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_request,
  output logic                     mem_write,
  input  logic                     mem_grant,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [BLOCK_WIDTH-1:0]   mem_write_block,
  input  logic [BLOCK_WIDTH-1:0]   mem_read_block,
  output logic                     corrected_valid,
  output logic [ADDRESS_WIDTH-1:0] corrected_address,
  output logic [COUNT_WIDTH-1:0]   corrected_count
);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, WRITE} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(DEPTH - 1);

  state_t                   state_reg, state_next;
  logic                     busy_reg, busy_next;
  logic                     done_reg, done_next;
  logic                     mem_request_reg, mem_request_next;
  logic                     mem_write_reg, mem_write_next;
  logic [ADDRESS_WIDTH-1:0] mem_address_reg, mem_address_next;
  logic [BLOCK_WIDTH-1:0]   mem_write_block_reg, mem_write_block_next;
  logic                     corrected_valid_reg, corrected_valid_next;
  logic [ADDRESS_WIDTH-1:0] corrected_address_reg, corrected_address_next;
  logic [COUNT_WIDTH-1:0]   corrected_count_reg, corrected_count_next;
  logic                     advance;
  logic                     sweep_go;

  logic [DATA_WIDTH-1:0]    voted_data;
  logic [REPETITION-2:0]    copy_diff;
  logic                     read_error;

  // Per-bit majority across all copies of the captured block.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_vote
    logic [REPETITION-1:0] bit_copies;
    for (genvar gk = 0; gk < REPETITION; gk++) begin : g_copy
      assign bit_copies[gk] = mem_read_block[gk*DATA_WIDTH + gi];
    end
    assign voted_data[gi] = ($countones(bit_copies) > (REPETITION / 2));
  end

  // A word needs repair when any redundant copy disagrees with the data copy.
  for (genvar gi = 1; gi < REPETITION; gi++) begin : g_diff
    assign copy_diff[gi-1] = (mem_read_block[gi*DATA_WIDTH +: DATA_WIDTH]
                              != mem_read_block[0 +: DATA_WIDTH]);
  end
  assign read_error = |copy_diff;

`ifdef REPETITION_SCRUBBER_PERIODIC_EN
  localparam int TIMER_WIDTH = $clog2(SCRUB_INTERVAL) + 1;
  logic [TIMER_WIDTH-1:0] idle_timer_reg;

  assign sweep_go = (state_reg == IDLE) &&
                    (start || (idle_timer_reg == TIMER_WIDTH'(SCRUB_INTERVAL - 1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_timer_reg <= '0;
    end else if ((state_reg != IDLE) || sweep_go) begin
      idle_timer_reg <= '0;
    end else begin
      idle_timer_reg <= idle_timer_reg + 1'b1;
    end
  end
`else
  assign sweep_go = start;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg             <= IDLE;
      busy_reg              <= 1'b0;
      done_reg              <= 1'b0;
      mem_request_reg       <= 1'b0;
      mem_write_reg         <= 1'b0;
      mem_address_reg       <= '0;
      mem_write_block_reg   <= '0;
      corrected_valid_reg   <= 1'b0;
      corrected_address_reg <= '0;
      corrected_count_reg   <= '0;
    end else begin
      state_reg             <= state_next;
      busy_reg              <= busy_next;
      done_reg              <= done_next;
      mem_request_reg       <= mem_request_next;
      mem_write_reg         <= mem_write_next;
      mem_address_reg       <= mem_address_next;
      mem_write_block_reg   <= mem_write_block_next;
      corrected_valid_reg   <= corrected_valid_next;
      corrected_address_reg <= corrected_address_next;
      corrected_count_reg   <= corrected_count_next;
    end
  end

  always_comb begin
    state_next             = state_reg;
    busy_next              = busy_reg;
    done_next              = 1'b0;
    mem_request_next       = mem_request_reg;
    mem_write_next         = mem_write_reg;
    mem_address_next       = mem_address_reg;
    mem_write_block_next   = mem_write_block_reg;
    corrected_valid_next   = 1'b0;
    corrected_address_next = corrected_address_reg;
    corrected_count_next   = corrected_count_reg;
    advance                = 1'b0;

    case (state_reg)
      IDLE: begin
        if (sweep_go) begin
          state_next           = READ;
          busy_next            = 1'b1;
          mem_request_next     = 1'b1;
          mem_write_next       = 1'b0;
          mem_address_next     = '0;
          corrected_count_next = '0;
        end
      end
      READ: begin
        if (mem_grant) begin
          state_next       = CAPTURE;
          mem_request_next = 1'b0;
        end
      end
      CAPTURE: begin
        if (read_error) begin
          state_next           = WRITE;
          mem_write_block_next = {REPETITION{voted_data}};
          mem_request_next     = 1'b1;
          mem_write_next       = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      WRITE: begin
        if (mem_grant) begin
          corrected_valid_next   = 1'b1;
          corrected_address_next = mem_address_reg;
          if (corrected_count_reg != '1) begin
            corrected_count_next = corrected_count_reg + 1'b1;
          end
          mem_request_next = 1'b0;
          mem_write_next   = 1'b0;
          advance          = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Move to the next word, or finish the sweep after the last one.
    if (advance) begin
      if (mem_address_reg == LAST_ADDRESS) begin
        state_next       = IDLE;
        busy_next        = 1'b0;
        done_next        = 1'b1;
        mem_request_next = 1'b0;
        mem_write_next   = 1'b0;
      end else begin
        state_next       = READ;
        mem_address_next = mem_address_reg + 1'b1;
        mem_request_next = 1'b1;
        mem_write_next   = 1'b0;
      end
    end
  end

  assign busy              = busy_reg;
  assign done              = done_reg;
  assign mem_request       = mem_request_reg;
  assign mem_write         = mem_write_reg;
  assign mem_address       = mem_address_reg;
  assign mem_write_block   = mem_write_block_reg;
  assign corrected_valid   = corrected_valid_reg;
  assign corrected_address = corrected_address_reg;
  assign corrected_count   = corrected_count_reg;

endmodule

// File: tb/tb_repetition_scrubber.sv
// Directed bench for repetition_scrubber: 1-cycle-latency memory model, per-access grant
// throttling, and hand-computed expected latencies, addresses and blocks.
module tb_repetition_scrubber;

  localparam int BW    = 24;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef REPETITION_SCRUBBER_PERIODIC_EN
  localparam int INTERVAL = 8;
`else
  localparam int INTERVAL = 1024;
`endif
  localparam logic [BW-1:0] CLEAN = {3{8'hA5}};

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, mem_request, mem_write;
  logic          mem_grant = 1'b1;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_write_block;
  logic [BW-1:0] rd_block = '0;
  logic          corrected_valid;
  logic [AW-1:0] corrected_address;
  logic [15:0]   corrected_count;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic reset_q = 1'b1;

  logic [BW-1:0] mem [DEPTH];
  logic          bd_en = 1'b0, bd_fill = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [BW-1:0] bd_data = '0;

  int read_stall_addr = -1, read_stall_n = 0;
  int write_stall_addr = -1, write_stall_n = 0;
  int stall_cnt = 0, need = 0;
  logic pend_stalled = 1'b0, p_wr = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [BW-1:0] p_block = '0;

  int rd_addr_q[$], rd_cycle_q[$], wr_addr_q[$], cv_addr_q[$];
  logic [BW-1:0] wr_block_q[$];
  int done_count = 0;

  repetition_scrubber #(.SCRUB_INTERVAL(INTERVAL)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_request(mem_request), .mem_write(mem_write), .mem_grant(mem_grant),
    .mem_address(mem_address), .mem_write_block(mem_write_block),
    .mem_read_block(rd_block), .corrected_valid(corrected_valid),
    .corrected_address(corrected_address), .corrected_count(corrected_count)
  );

  always #5 clock = ~clock;

  // Memory model: one-cycle read latency, backdoor fill/poke for setup.
  always @(posedge clock) begin
    cycle   <= cycle + 1;
    reset_q <= reset;
    if (bd_fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= bd_data;
    end else if (bd_en) begin
      mem[bd_addr] <= bd_data;
    end
    if (mem_request && mem_grant) begin
      if (mem_write) mem[mem_address] <= mem_write_block;
      else           rd_block <= mem[mem_address];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Grant driver and access monitor.
  always @(negedge clock) begin
    if (pend_stalled && !reset_q) begin
      check("stall_req",   {63'd0, mem_request}, 64'd1);
      check("stall_wr",    {63'd0, mem_write}, {63'd0, p_wr});
      check("stall_addr",  64'(mem_address), 64'(p_addr));
      check("stall_block", 64'(mem_write_block), 64'(p_block));
    end
    need = 0;
    if (mem_request) begin
      if (mem_write && int'(mem_address) == write_stall_addr)       need = write_stall_n;
      else if (!mem_write && int'(mem_address) == read_stall_addr)  need = read_stall_n;
    end
    if (mem_request && stall_cnt < need) begin
      mem_grant    = 1'b0;
      stall_cnt++;
      pend_stalled = 1'b1;
      p_wr         = mem_write;
      p_addr       = mem_address;
      p_block      = mem_write_block;
    end else begin
      mem_grant    = 1'b1;
      stall_cnt    = 0;
      pend_stalled = 1'b0;
      if (mem_request) begin
        if (mem_write) begin
          wr_addr_q.push_back(int'(mem_address));
          wr_block_q.push_back(mem_write_block);
          $display("cycle %0d write addr %0d block %h", cycle, mem_address, mem_write_block);
        end else begin
          rd_addr_q.push_back(int'(mem_address));
          rd_cycle_q.push_back(cycle);
          $display("cycle %0d read addr %0d", cycle, mem_address);
        end
      end
    end
    if (corrected_valid) cv_addr_q.push_back(int'(corrected_address));
    if (done) done_count++;
  end

  task automatic poke(input int a, input logic [BW-1:0] d);
    @(negedge clock);
    bd_en = 1'b1; bd_addr = AW'(a); bd_data = d;
    @(negedge clock);
    bd_en = 1'b0;
  endtask

  task automatic do_start(output int t);
    @(negedge clock);
    start = 1'b1;
    t = cycle;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int d);
    bit seen = 0;
    d = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (done) begin
        d = cycle; seen = 1;
        break;
      end
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    @(negedge clock);
  endtask

  task automatic sweep(output int lat, output int rs, output int ws, output int cs);
    int t, d;
    rs = rd_addr_q.size(); ws = wr_addr_q.size(); cs = cv_addr_q.size();
    do_start(t);
    wait_done(d);
    lat = d - t;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  {63'd0, busy}, 64'd0);
    check({tag, "_done"},  {63'd0, done}, 64'd0);
    check({tag, "_req"},   {63'd0, mem_request}, 64'd0);
    check({tag, "_wr"},    {63'd0, mem_write}, 64'd0);
    check({tag, "_addr"},  64'(mem_address), 64'd0);
    check({tag, "_block"}, 64'(mem_write_block), 64'd0);
    check({tag, "_cv"},    {63'd0, corrected_valid}, 64'd0);
    check({tag, "_caddr"}, 64'(corrected_address), 64'd0);
    check({tag, "_count"}, 64'(corrected_count), 64'd0);
  endtask

  initial begin
    int lat, rs, ws, cs, c0, t, d1, d2, n, dc;
    bit found;
    repeat (2) @(negedge clock);
    bd_fill = 1'b1; bd_data = CLEAN;
    @(negedge clock);
    bd_fill = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    c0 = cycle;
    @(negedge clock);
    check_reset_values("reset");

`ifdef REPETITION_SCRUBBER_PERIODIC_EN
    wait_done(d1);
    check("p_first_read", 64'(rd_cycle_q[0] - c0), 64'd8);
    check("p_sweep_len",  64'(d1 - rd_cycle_q[0]), 64'd32);
    check("p_reads1",     64'(rd_addr_q.size()), 64'd16);
    n = rd_addr_q.size();
    wait_done(d2);
    check("p_second_read", 64'(rd_cycle_q[n] - d1), 64'd8);
    check("p_second_addr", 64'(rd_addr_q[n]), 64'd0);
    check("p_writes",      64'(wr_addr_q.size()), 64'd0);
`else
    // Clean memory.
    sweep(lat, rs, ws, cs);
    check("clean_latency", 64'(lat), 64'd33);
    check("clean_reads", 64'(rd_addr_q.size() - rs), 64'd16);
    for (int i = 0; i < DEPTH; i++) check("clean_rd_addr", 64'(rd_addr_q[rs+i]), 64'(i));
    check("clean_writes", 64'(wr_addr_q.size() - ws), 64'd0);
    check("clean_count", 64'(corrected_count), 64'd0);
    check("clean_busy", {63'd0, busy}, 64'd0);

    // Single-bit flip in copy 1 of word 5, then a re-sweep of the repaired array.
    poke(5, CLEAN ^ 24'h000200);
    sweep(lat, rs, ws, cs);
    check("flip_latency", 64'(lat), 64'd34);
    check("flip_writes", 64'(wr_addr_q.size() - ws), 64'd1);
    check("flip_wr_addr", 64'(wr_addr_q[ws]), 64'd5);
    check("flip_wr_block", 64'(wr_block_q[ws]), 64'(CLEAN));
    check("flip_cv_n", 64'(cv_addr_q.size() - cs), 64'd1);
    check("flip_cv_addr", 64'(cv_addr_q[cs]), 64'd5);
    check("flip_count", 64'(corrected_count), 64'd1);
    check("flip_mem5", 64'(mem[5]), 64'(CLEAN));
    sweep(lat, rs, ws, cs);
    check("resweep_count", 64'(corrected_count), 64'd0);
    check("resweep_latency", 64'(lat), 64'd33);

    // Data copy wrong on the last word.
    poke(15, {8'h3C, 8'h3C, 8'hFF});
    sweep(lat, rs, ws, cs);
    check("data_latency", 64'(lat), 64'd34);
    check("data_wr_addr", 64'(wr_addr_q[ws]), 64'd15);
    check("data_wr_block", 64'(wr_block_q[ws]), 64'({3{8'h3C}}));
    check("data_cv_addr", 64'(cv_addr_q[cs]), 64'd15);
    check("data_count", 64'(corrected_count), 64'd1);

    // Grant backpressure: 4 cycles on read of word 2, 3 cycles on the write of word 7.
    poke(7, CLEAN ^ 24'h080000);
    read_stall_addr = 2;  read_stall_n = 4;
    write_stall_addr = 7; write_stall_n = 3;
    sweep(lat, rs, ws, cs);
    read_stall_addr = -1; read_stall_n = 0;
    write_stall_addr = -1; write_stall_n = 0;
    check("bp_latency", 64'(lat), 64'd41);
    check("bp_wr_addr", 64'(wr_addr_q[ws]), 64'd7);
    check("bp_wr_block", 64'(wr_block_q[ws]), 64'(CLEAN));
    check("bp_count", 64'(corrected_count), 64'd1);

    // Ignored start while busy, then reset during a stalled write-back.
    poke(4, {8'hA5, 8'hA4, 8'hA5});
    poke(9, CLEAN ^ 24'h000001);
    write_stall_addr = 9; write_stall_n = 100;
    rs = rd_addr_q.size();
    do_start(t);
    repeat (2) @(negedge clock);
    do_start(t);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (mem_request && mem_write && mem_address == 4'd9) begin
        found = 1;
        break;
      end
    end
    check("rst_write_reached", {63'd0, found}, 64'd1);
    check("rst_reads", 64'(rd_addr_q.size() - rs), 64'd10);
    check("rst_pre_count", 64'(corrected_count), 64'd1);
    dc = done_count;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    write_stall_addr = -1; write_stall_n = 0;
    check_reset_values("after_reset");
    check("rst_mem9_kept", 64'(mem[9]), 64'(CLEAN ^ 24'h000001));
    repeat (5) @(negedge clock);
    check("rst_no_done", 64'(done_count - dc), 64'd0);
    sweep(lat, rs, ws, cs);
    check("rst_fresh_first", 64'(rd_addr_q[rs]), 64'd0);
    check("rst_fresh_latency", 64'(lat), 64'd34);
    check("rst_fresh_count", 64'(corrected_count), 64'd1);
    check("rst_mem9_fixed", 64'(mem[9]), 64'(CLEAN));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/repetition_scrubber.md
# repetition_scrubber

Background scrubber for a memory array whose words are stored as repetition-code blocks (data in LSBs, REPETITION-1 copies above). On a start request it sweeps every address through a shared single-port memory interface. For each word it reads the block, majority-votes each bit, and writes back a freshly encoded block when any copy disagrees. It sits between the memory arbiter (request/grant) and the array, and reports progress and corrected-word statistics to a control/status register block.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per word
- REPETITION, 3, total copies per word; odd, ≥3
- DEPTH, 16, number of memory words; ≥2
- COUNT_WIDTH, 16, width of corrected-word counter
- SCRUB_INTERVAL, 1024, idle cycles between automatic sweeps (periodic build only)
- Derived: BLOCK_WIDTH = REPETITION*DATA_WIDTH; ADDRESS_WIDTH = max(1, $clog2(DEPTH))

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle sweep request; ignored while busy
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when a sweep finishes
- mem_request  out  1  memory access request to arbiter
- mem_write  out  1  qualifies mem_request: 1 = write, 0 = read
- mem_grant  in  1  arbiter grant; access executes in the cycle request and grant are both high
- mem_address  out  ADDRESS_WIDTH  word address
- mem_write_block  out  BLOCK_WIDTH  block to write
- mem_read_block  in  BLOCK_WIDTH  read data, valid exactly one cycle after a granted read
- corrected_valid  out  1  one-cycle pulse when a corrected write-back is granted
- corrected_address  out  ADDRESS_WIDTH  address of that write-back
- corrected_count  out  COUNT_WIDTH  corrected words in the current/last sweep; saturates at all-ones

## Operation
- Block layout: copy k (k=0 is data) at bits [k*DATA_WIDTH +: DATA_WIDTH].
- Vote: each corrected bit is the majority over the REPETITION copies. Error is flagged when any copy differs from copy 0.
- FSM states: IDLE, READ, CAPTURE, WRITE.
  - IDLE: all request outputs low. On start, go to READ with mem_address=0, clear corrected_count, set busy.
  - READ: mem_request=1, mem_write=0. Stays in READ until mem_grant, then goes to CAPTURE.
  - CAPTURE: mem_request=0. Votes mem_read_block.
    - If error: register mem_write_block = {REPETITION{corrected_data}} and go to WRITE.
    - If no error: advance.
  - WRITE: mem_request=1, mem_write=1, mem_write_block held stable. On mem_grant:
    - pulse corrected_valid with corrected_address=mem_address;
    - increment corrected_count (saturating);
    - advance.
- Advance: if mem_address==DEPTH-1, go to IDLE, pulse done and drop busy in the same cycle. Otherwise increment mem_address and go to READ.
- Request discipline: mem_request, mem_write, mem_address and mem_write_block do not change while a request is pending and ungranted.
- start during busy has no effect and is not queued.

## Timing
- Reset values: busy=0, done=0, mem_request=0, mem_write=0, mem_address=0, mem_write_block=0, corrected_valid=0, corrected_address=0, corrected_count=0; FSM in IDLE; periodic timer at 0.
- All outputs are registered.
- start at cycle T: READ (mem_request=1) at T+1.
- Clean word with immediate grant: 2 cycles (READ, CAPTURE).
- Corrected word with immediate grants: 3 cycles (READ, CAPTURE, WRITE).
- Clean sweep with constant grant: done high at T+1+2*DEPTH; busy high for 2*DEPTH cycles.
- Grant withheld N cycles: the access stalls exactly N extra cycles; no other state changes.
- Reset mid-sweep: next cycle returns to reset values. A pending write is abandoned (request dropped), no done pulse, and the count is cleared.
- corrected_count holds its value after done until the next accepted start.

## Configuration
- Macro REPETITION_SCRUBBER_PERIODIC_EN.
- Defined: an idle timer counts cycles spent in IDLE (cleared on leaving IDLE). When it reaches SCRUB_INTERVAL-1 it starts a sweep exactly as start would. An explicit start still works and resets the timer.
- Undefined: no timer logic; SCRUB_INTERVAL is unused; sweeps start only on start.

## Test plan
(Defaults; memory model with 1-cycle read latency; bench grants every request unless stated.)
- Clean memory: all words {3{8'hA5}}, start pulse.
  - Expect 16 reads at addresses 0..15, no write.
  - done at start+33, corrected_count=0.
- Single-bit flip: word 5 bit 9 flipped (copy 1).
  - Expect one write at address 5 of {3{8'hA5}}, corrected_valid with corrected_address=5, corrected_count=1.
  - A second start then reports corrected_count=0.
- Data-copy error: word 15 stored as {8'h3C, 8'h3C, 8'hFF}.
  - Expect write of {3{8'h3C}} at address 15.
  - done arrives after this final write, 1 cycle later than the clean-memory case.
- Grant backpressure: grant held low 4 cycles on the read of word 2 and 3 cycles on a corrected write.
  - Expect address, write flag and write block stable throughout.
  - Sweep finishes exactly 7 cycles late.
- Reset and ignored start: pulse start again while busy, then assert reset mid-write.
  - The second start has no effect.
  - After reset: all outputs at reset values, no done; a fresh start sweeps from address 0.
- Periodic (macro defined, SCRUB_INTERVAL=8): no start pulses.
  - First READ 8 cycles after reset release.
  - Next sweep begins 8 idle cycles after each done.
